// File: rtl/kim_branch_resolver.sv
// kim_branch_resolver
//   Resolves conditional branches in the ID stage, checks the IF prediction and
//   maintains a 2-bit saturating branch history table plus a mispredict counter.
//
// Ports
//   clk, reset_n                  clock (rising edge), asynchronous active-low reset
//   id_valid, is_branch, br_op    ID instruction qualifiers and branch type
//   r_data1, r_data2              forwarded rs / rt operands
//   operands_ready                both operands valid this cycle
//   id_pc, branch_target          PC of the branch and its taken target
//   pred_taken                    prediction IF used for this branch
//   flush                         cancels the branch in ID and any pending resolution
//   if_pc, bht_pred               IF-stage BHT lookup (combinational)
//   stall_out                     hold PC and IF/ID while operands are not ready
//   resolve_valid, taken          one-cycle outcome pulse and resolved direction
//   mispredict, redirect_pc       mispredict flag and corrected fetch address
//   flush_if_id                   flush IF/ID on mispredict
//   mispredict_cnt                saturating mispredict count
module kim_branch_resolver #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned BHT_DEPTH  = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic                  is_branch,
    input  logic [2:0]            br_op,
    input  logic [DATA_WIDTH-1:0] r_data1,
    input  logic [DATA_WIDTH-1:0] r_data2,
    input  logic                  operands_ready,
    input  logic [PC_WIDTH-1:0]   id_pc,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic                  pred_taken,
    input  logic                  flush,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  bht_pred,
    output logic                  stall_out,
    output logic                  resolve_valid,
    output logic                  taken,
    output logic                  mispredict,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  flush_if_id,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

    localparam int unsigned IdxW = $clog2(BHT_DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResolve} state_t;

    state_t                state_q;
    logic                  taken_q;
    logic                  pred_q;
    logic [PC_WIDTH-1:0]   redirect_q;
    logic [IdxW-1:0]       idx_q;
    logic [1:0]            bht_q [BHT_DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  br_present;
    logic                  accept;
    logic                  cond_taken;
    logic                  neg;
    logic                  zero;
    logic                  eq;
    logic [PC_WIDTH-1:0]   pc_plus4;

    assign br_present = id_valid & is_branch;
    assign accept     = br_present & operands_ready & ~flush;
    assign stall_out  = br_present & ~operands_ready & ~flush;

    assign neg      = r_data1[DATA_WIDTH-1];
    assign zero     = (r_data1 == '0);
    assign eq       = (r_data1 == r_data2);
    assign pc_plus4 = id_pc + PC_WIDTH'(4);

    always_comb begin
        cond_taken = 1'b0;
        case (br_op)
            3'b000:  cond_taken = eq;
            3'b001:  cond_taken = ~eq;
            3'b010:  cond_taken = neg | zero;
            3'b011:  cond_taken = ~neg & ~zero;
            3'b100:  cond_taken = neg;
            3'b101:  cond_taken = ~neg;
            default: cond_taken = 1'b0;
        endcase
    end

    // Outcome is captured at accept; the target/fall-through choice is folded
    // into redirect_q so only one PC register is needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            taken_q    <= 1'b0;
            pred_q     <= 1'b0;
            redirect_q <= '0;
            idx_q      <= '0;
        end else begin
            if (accept) begin
                taken_q    <= cond_taken;
                pred_q     <= pred_taken;
                redirect_q <= cond_taken ? branch_target : pc_plus4;
                idx_q      <= id_pc[IdxW+1:2];
            end
            unique case (state_q)
                StIdle: begin
                    if (accept)         state_q <= StResolve;
                    else if (stall_out) state_q <= StWait;
                end
                StWait: begin
                    if (accept)                       state_q <= StResolve;
                    else if (flush || !br_present)    state_q <= StIdle;
                end
                StResolve: begin
                    if (accept)         state_q <= StResolve;
                    else if (stall_out) state_q <= StWait;
                    else                state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A flush during the resolve cycle kills the pulse and everything keyed on it.
    assign resolve_valid  = (state_q == StResolve) & ~flush;
    assign taken          = taken_q;
    assign mispredict     = resolve_valid & (taken_q != pred_q);
    assign flush_if_id    = resolve_valid & mispredict;
    assign redirect_pc    = redirect_q;
    assign mispredict_cnt = cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (resolve_valid) begin
            if (taken_q) begin
                if (bht_q[idx_q] != 2'b11) bht_q[idx_q] <= bht_q[idx_q] + 2'b01;
            end else begin
                if (bht_q[idx_q] != 2'b00) bht_q[idx_q] <= bht_q[idx_q] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (mispredict && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // Read returns the stored value; an update on the same edge is not bypassed.
    assign bht_pred = bht_q[if_pc[IdxW+1:2]][1];

    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[PC_WIDTH-1:IdxW+2], if_pc[1:0]};

endmodule

// File: tb/tb_kim_branch_resolver.sv
module tb_kim_branch_resolver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, is_branch, operands_ready, pred_taken, flush;
    logic [2:0]  br_op;
    logic [31:0] r_data1, r_data2, id_pc, branch_target, if_pc;
    logic        bht_pred, stall_out, resolve_valid, taken, mispredict, flush_if_id;
    logic [31:0] redirect_pc;
    logic [1:0]  mispredict_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    kim_branch_resolver #(
        .DATA_WIDTH(32),
        .PC_WIDTH  (32),
        .BHT_DEPTH (16),
        .CNT_WIDTH (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .id_valid      (id_valid),
        .is_branch     (is_branch),
        .br_op         (br_op),
        .r_data1       (r_data1),
        .r_data2       (r_data2),
        .operands_ready(operands_ready),
        .id_pc         (id_pc),
        .branch_target (branch_target),
        .pred_taken    (pred_taken),
        .flush         (flush),
        .if_pc         (if_pc),
        .bht_pred      (bht_pred),
        .stall_out     (stall_out),
        .resolve_valid (resolve_valid),
        .taken         (taken),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .flush_if_id   (flush_if_id),
        .mispredict_cnt(mispredict_cnt)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        exp_taken;
        logic        exp_mis;
        logic [31:0] exp_redirect;
        logic [1:0]  exp_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_idle();
        id_valid       = 1'b0;
        is_branch      = 1'b0;
        operands_ready = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic set_br(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic pr, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic rdy);
        id_valid       = 1'b1;
        is_branch      = 1'b1;
        operands_ready = rdy;
        flush          = 1'b0;
        br_op          = op;
        r_data1        = a;
        r_data2        = b;
        pred_taken     = pr;
        id_pc          = pc;
        branch_target  = tgt;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rv"},   32'(resolve_valid),  32'h0);
        chk({tag, "_tk"},   32'(taken),          32'h0);
        chk({tag, "_mis"},  32'(mispredict),     32'h0);
        chk({tag, "_fl"},   32'(flush_if_id),    32'h0);
        chk({tag, "_rpc"},  redirect_pc,         32'h0);
        chk({tag, "_cnt"},  32'(mispredict_cnt), 32'h0);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'h1234,     32'h1234, 1'b0, 32'h100,      32'h400, 1'b1, 1'b1, 32'h400, 2'd1};
        vecs[1]  = '{3'b101, 32'hFFFFFFFF, 32'h0,    1'b0, 32'h104,      32'h500, 1'b0, 1'b0, 32'h108, 2'd1};
        vecs[2]  = '{3'b010, 32'h0,        32'h0,    1'b1, 32'h108,      32'h600, 1'b1, 1'b0, 32'h600, 2'd1};
        vecs[3]  = '{3'b011, 32'h80000000, 32'h0,    1'b1, 32'h10C,      32'h700, 1'b0, 1'b1, 32'h110, 2'd2};
        vecs[4]  = '{3'b111, 32'h5,        32'h0,    1'b0, 32'h110,      32'h800, 1'b0, 1'b0, 32'h114, 2'd2};
        vecs[5]  = '{3'b001, 32'h1,        32'h2,    1'b1, 32'h114,      32'h900, 1'b1, 1'b0, 32'h900, 2'd2};
        vecs[6]  = '{3'b100, 32'h80000000, 32'h0,    1'b0, 32'h118,      32'hA00, 1'b1, 1'b1, 32'hA00, 2'd3};
        vecs[7]  = '{3'b101, 32'h0,        32'h0,    1'b1, 32'h11C,      32'hB00, 1'b1, 1'b0, 32'hB00, 2'd3};
        vecs[8]  = '{3'b000, 32'h1,        32'h2,    1'b1, 32'hFFFFFFFC, 32'h40,  1'b0, 1'b1, 32'h0,   2'd3};
        vecs[9]  = '{3'b011, 32'h1,        32'h0,    1'b0, 32'h120,      32'hC00, 1'b1, 1'b1, 32'hC00, 2'd3};
        vecs[10] = '{3'b100, 32'h7FFFFFFF, 32'h0,    1'b0, 32'h124,      32'hD00, 1'b0, 1'b0, 32'h128, 2'd3};
        vecs[11] = '{3'b010, 32'h1,        32'h0,    1'b0, 32'h128,      32'hE00, 1'b0, 1'b0, 32'h12C, 2'd3};
        vecs[12] = '{3'b110, 32'h7,        32'h7,    1'b1, 32'h12C,      32'hF00, 1'b0, 1'b1, 32'h130, 2'd3};

        reset_n = 1'b0;
        set_idle();
        br_op = 3'b000; r_data1 = '0; r_data2 = '0; pred_taken = 1'b0;
        id_pc = '0; branch_target = '0; if_pc = 32'h40;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_bht_pred", 32'(bht_pred), 32'h0);
        chk("reset_stall", 32'(stall_out), 32'h0);
        @(negedge clk) reset_n = 1'b1;

        // Flush in the resolve cycle of a mispredicted branch (BHT index 0)
        tick(); set_br(3'b000, 32'h1234, 32'h1234, 1'b0, 32'h40, 32'h400, 1'b1);
        settle(); chk("fl_accept_stall", 32'(stall_out), 32'h0);
        tick(); set_idle(); flush = 1'b1;
        settle();
        chk("fl_rv", 32'(resolve_valid), 32'h0);
        chk("fl_flush_if_id", 32'(flush_if_id), 32'h0);
        chk("fl_mis", 32'(mispredict), 32'h0);
        tick(); set_idle();
        settle();
        chk("fl_after_rv", 32'(resolve_valid), 32'h0);
        chk("fl_after_cnt", 32'(mispredict_cnt), 32'h0);
        chk("fl_after_bht", 32'(bht_pred), 32'h0);

        // Three back-to-back taken branches at 0x40: BHT[0] 01->10->11->11
        tick(); set_br(3'b000, 32'h0, 32'h0, 1'b1, 32'h40, 32'h80, 1'b1);
        settle(); chk("walk_pre_bht", 32'(bht_pred), 32'h0);
        tick();
        settle();
        chk("walk_r1_rv", 32'(resolve_valid), 32'h1);
        chk("walk_r1_tk", 32'(taken), 32'h1);
        chk("walk_r1_bht_noBypass", 32'(bht_pred), 32'h0);
        tick();
        settle();
        chk("walk_r2_rv", 32'(resolve_valid), 32'h1);
        chk("walk_r2_bht", 32'(bht_pred), 32'h1);
        tick(); set_idle();
        settle();
        chk("walk_r3_rv", 32'(resolve_valid), 32'h1);
        chk("walk_r3_rpc", redirect_pc, 32'h80);
        chk("walk_r3_bht", 32'(bht_pred), 32'h1);
        tick();
        settle();
        chk("walk_idle_rv", 32'(resolve_valid), 32'h0);
        chk("walk_sat_bht", 32'(bht_pred), 32'h1);
        // Not-taken twice: 11->10 (still predicts taken) ->01
        tick(); set_br(3'b001, 32'h0, 32'h0, 1'b0, 32'h40, 32'h80, 1'b1);
        tick(); set_idle();
        settle();
        chk("nt1_rv", 32'(resolve_valid), 32'h1);
        chk("nt1_tk", 32'(taken), 32'h0);
        chk("nt1_mis", 32'(mispredict), 32'h0);
        chk("nt1_rpc", redirect_pc, 32'h44);
        tick();
        settle(); chk("nt1_bht", 32'(bht_pred), 32'h1);
        tick(); set_br(3'b001, 32'h0, 32'h0, 1'b0, 32'h40, 32'h80, 1'b1);
        tick(); set_idle();
        tick();
        settle();
        chk("nt2_bht", 32'(bht_pred), 32'h0);
        chk("nt2_cnt", 32'(mispredict_cnt), 32'h0);

        // Operands not ready for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick(); set_br(3'b001, 32'h1, 32'h2, 1'b1, 32'h200, 32'h300, 1'b0);
            settle();
            chk($sformatf("stall_c%0d", i), 32'(stall_out), 32'h1);
            chk($sformatf("stall_rv_c%0d", i), 32'(resolve_valid), 32'h0);
        end
        tick(); operands_ready = 1'b1;
        settle();
        chk("stall_ready_stall", 32'(stall_out), 32'h0);
        chk("stall_ready_rv", 32'(resolve_valid), 32'h0);
        tick(); set_idle();
        settle();
        chk("stall_res_rv", 32'(resolve_valid), 32'h1);
        chk("stall_res_tk", 32'(taken), 32'h1);
        chk("stall_res_mis", 32'(mispredict), 32'h0);
        chk("stall_res_rpc", redirect_pc, 32'h300);
        tick();
        settle();
        chk("stall_done_rv", 32'(resolve_valid), 32'h0);

        // Table of single branches
        for (int i = 0; i < 13; i++) begin
            tick();
            set_br(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].pred, vecs[i].pc, vecs[i].tgt, 1'b1);
            settle();
            chk($sformatf("v%0d_stall", i), 32'(stall_out), 32'h0);
            tick(); set_idle();
            settle();
            chk($sformatf("v%0d_rv", i),  32'(resolve_valid), 32'h1);
            chk($sformatf("v%0d_tk", i),  32'(taken),         32'(vecs[i].exp_taken));
            chk($sformatf("v%0d_mis", i), 32'(mispredict),    32'(vecs[i].exp_mis));
            chk($sformatf("v%0d_fl", i),  32'(flush_if_id),   32'(vecs[i].exp_mis));
            chk($sformatf("v%0d_rpc", i), redirect_pc,        vecs[i].exp_redirect);
            tick();
            settle();
            chk($sformatf("v%0d_idle_rv", i), 32'(resolve_valid), 32'h0);
            chk($sformatf("v%0d_cnt", i), 32'(mispredict_cnt), 32'(vecs[i].exp_cnt));
        end

        // Reset asserted while waiting for operands
        tick(); set_br(3'b001, 32'h1, 32'h2, 1'b1, 32'h200, 32'h300, 1'b0);
        tick();
        #2 reset_n = 1'b0;
        #1 chk_all_zero("rst_wait");
        set_idle();
        @(negedge clk) reset_n = 1'b1;
        tick();
        settle();
        chk("rst_wait_after_rv", 32'(resolve_valid), 32'h0);

        // Reset asserted in the resolve cycle of a mispredicted branch
        tick(); set_br(3'b000, 32'h9, 32'h9, 1'b0, 32'h300, 32'h444, 1'b1);
        tick(); set_idle();
        #1;
        chk("rst_res_pre_rv", 32'(resolve_valid), 32'h1);
        chk("rst_res_pre_fl", 32'(flush_if_id), 32'h1);
        reset_n = 1'b0;
        #1 chk_all_zero("rst_res");
        @(negedge clk) reset_n = 1'b1;
        tick();
        settle();
        chk("rst_res_after_rv", 32'(resolve_valid), 32'h0);
        chk("rst_res_after_cnt", 32'(mispredict_cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/kim_branch_resolver.md
# kim_branch_resolver

Parametrised branch-resolution unit for the ID stage of the pipelined MIPS core. It evaluates six conditional-branch types on forwarded register operands and waits (stalling ID) until those operands are ready. It registers the outcome, checks it against the IF-stage prediction, and drives PC redirect and IF/ID flush on a mispredict. It also owns a 2-bit saturating branch history table (BHT) that IF reads for prediction, plus a saturating mispredict counter.

## Interface
- DATA_WIDTH, 32, register operand width
- PC_WIDTH, 32, program counter width
- BHT_DEPTH, 16, BHT entries; power of two, at least 2; index = pc[log2(BHT_DEPTH)+1:2]
- CNT_WIDTH, 16, mispredict counter width

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- is_branch  in  1  ID instruction is a conditional branch
- br_op  in  3  000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ; 110/111 evaluate as not-taken
- r_data1  in  DATA_WIDTH  rs operand, after forwarding
- r_data2  in  DATA_WIDTH  rt operand, after forwarding; used by BEQ/BNE only
- operands_ready  in  1  hazard unit: both operands valid this cycle
- id_pc  in  PC_WIDTH  PC of the ID instruction
- branch_target  in  PC_WIDTH  computed taken target
- pred_taken  in  1  prediction that IF used for this instruction
- flush  in  1  cancel the branch in ID and any pending resolution
- if_pc  in  PC_WIDTH  IF-stage PC for BHT lookup
- bht_pred  out  1  MSB of BHT[if_pc index]; combinational read
- stall_out  out  1  hold PC and IF/ID while waiting for operands
- resolve_valid  out  1  one-cycle pulse: outcome outputs valid
- taken  out  1  resolved direction
- mispredict  out  1  taken != captured pred_taken; qualified by resolve_valid
- redirect_pc  out  PC_WIDTH  taken ? target : pc+4; valid with mispredict
- flush_if_id  out  1  equals resolve_valid & mispredict
- mispredict_cnt  out  CNT_WIDTH  saturating mispredict count

## Operation
- accept = id_valid & is_branch & operands_ready & !flush.
- On accept, register on the clock edge: condition result, target, id_pc+4 (modulo 2^PC_WIDTH), pred_taken, and BHT index from id_pc.
- Condition rules:
  - BEQ/BNE compare full-width equality.
  - BLEZ/BGTZ/BLTZ/BGEZ compare r_data1 as signed against 0.
- stall_out = id_valid & is_branch & !operands_ready & !flush. It is combinational and independent of FSM state.
- FSM states and transitions:
  - IDLE: accept -> RESOLVE; branch present but not ready -> WAIT.
  - WAIT: accept -> RESOLVE; flush or !(id_valid & is_branch) -> IDLE; otherwise stay.
  - RESOLVE: lasts one cycle. accept -> RESOLVE (back-to-back); branch not ready -> WAIT; else IDLE.
- resolve_valid = (state == RESOLVE) & !flush. A flush in the RESOLVE cycle suppresses every output pulse, the BHT update and the counter increment.
- BHT update happens on the edge that ends a valid RESOLVE cycle:
  - taken: counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.
- Lookup/update collision on the same index: bht_pred returns the pre-update value (no bypass).
- mispredict_cnt increments on each valid mispredict and holds at all-ones.

## Timing
- Reset values:
  - state: IDLE.
  - All outputs 0: resolve_valid, taken, mispredict, flush_if_id, redirect_pc, mispredict_cnt.
  - Every BHT entry is 01 (weakly not-taken), so bht_pred = 0.
- Reset asserted mid-WAIT or mid-RESOLVE: return to IDLE immediately and drop any pending pulse.
- Latency:
  - Accept in cycle T -> resolve_valid, taken, mispredict, redirect_pc and flush_if_id in cycle T+1.
  - BHT and counter updates are visible from T+2.
- Operands not ready: stall_out is high in every cycle until operands_ready. A branch whose operands become ready in cycle T+k resolves in T+k+1.
- Throughput: one branch per cycle (back-to-back RESOLVE).
- stall_out, bht_pred: same-cycle combinational. All other outputs are registered.

## Test plan
- BEQ, r_data1=r_data2=0x1234, pred_taken=0, target=0x400, id_pc=0x100 -> next cycle: resolve_valid=1, taken=1, mispredict=1, redirect_pc=0x400, flush_if_id=1, mispredict_cnt=1.
- BGEZ, r_data1=0xFFFFFFFF, pred_taken=0 -> taken=0, mispredict=0. BLEZ with 0x0 -> taken=1. BGTZ with 0x80000000 -> taken=0. br_op=111 -> taken=0.
- operands_ready low for 3 cycles with BNE pending -> stall_out=1 for exactly 3 cycles; resolve_valid pulses in the cycle after ready rises.
- Branch resolves taken three times at id_pc=0x40 -> BHT[0] walks 01->10->11->11; if_pc=0x40 yields bht_pred=1 from the cycle after the first update onward.
- flush asserted in the RESOLVE cycle of a mispredicted branch -> resolve_valid=0, flush_if_id=0, BHT and mispredict_cnt unchanged.
- Back-to-back accepts in cycles T and T+1 -> two consecutive resolve_valid pulses. CNT_WIDTH=2 with 5 mispredicts -> mispredict_cnt saturates at 3. reset_n low during WAIT -> state IDLE, all outputs 0.
